// File: rtl/karatsuba_mult_seq.sv
// -----------------------------------------------------------------------------
// karatsuba_mult_seq
//
// Sequential Karatsuba multiplier. The two WIDTH-bit operands are reduced to
// sign + magnitude. Each magnitude is split into HALF-bit halves, and three
// half-size products are formed on a single shared (HALF+1)x(HALF+1)
// multiplier, one product per cycle:
//     A  = wl * yl
//     B  = wh * yh
//     DE = (wl + wh) * (yl + yh)
// They are recombined as P = B<<WIDTH + (DE - A - B)<<HALF + A.
// P is negated when the operand signs differ in signed mode.
//
// Fixed latency: the start edge is followed by PREP, MUL_A, MUL_B, MUL_DE,
// COMBINE and FINISH. PRONTO pulses for one cycle after the FINISH edge.
// A start held through the PRONTO cycle is accepted on the next edge, so
// operations can be issued every 7 cycles.
//
// Parameters
//   WIDTH        operand width; must be even and >= 4
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset
//   S            start request, sampled only in IDLE
//   SIGNED_MODE  1 = two's complement operands/result, 0 = unsigned
//   w, y         operands, latched on the start edge
//   result       2*WIDTH-bit product, held until the next completion
//   PRONTO       one-cycle completion pulse
//   BUSY         high whenever the controller is not in IDLE
// -----------------------------------------------------------------------------
module karatsuba_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               S,
    input  logic               SIGNED_MODE,
    input  logic [WIDTH-1:0]   w,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] result,
    output logic               PRONTO,
    output logic               BUSY
);

    localparam int HALF = WIDTH / 2;
    localparam int MW   = HALF + 1;      // shared multiplier operand width
    localparam int PW   = 2 * MW;        // shared multiplier product width (WIDTH+2)
    localparam int RW   = 2 * WIDTH;     // full product width

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREP    = 3'd1,
        MUL_A   = 3'd2,
        MUL_B   = 3'd3,
        MUL_DE  = 3'd4,
        COMBINE = 3'd5,
        FINISH  = 3'd6
    } state_t;

    state_t state_reg, state_next;

    // Index 0 holds the multiplicand (w), index 1 the multiplier (y).
    logic [1:0][WIDTH-1:0] op_reg, op_next;
    logic                  mode_reg, mode_next;
    logic [1:0][WIDTH-1:0] mag_reg, mag_next;
    logic [1:0][MW-1:0]    sum_reg, sum_next;
    logic                  neg_reg, neg_next;

    // A and B fit in WIDTH bits. They are kept at the multiplier's full width,
    // so that the recombination arithmetic works on a single uniform width.
    logic [PW-1:0]         a_reg, a_next;
    logic [PW-1:0]         b_reg, b_next;
    logic [PW-1:0]         de_reg, de_next;
    logic [RW-1:0]         p_reg, p_next;
    logic [RW-1:0]         result_reg, result_next;
    logic                  pronto_reg, pronto_next;

    // -------------------------------------------------------------------------
    // Operand conditioning, one copy per operand: sign, magnitude, half-sum.
    // In signed mode the most negative value negates to 2^(WIDTH-1). That value
    // is still correct when read as an unsigned WIDTH-bit magnitude.
    // -------------------------------------------------------------------------
    logic [1:0]            op_neg;
    logic [1:0][WIDTH-1:0] op_mag;
    logic [1:0][MW-1:0]    op_sum;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign op_neg[gi] = mode_reg & op_reg[gi][WIDTH-1];
            assign op_mag[gi] = op_neg[gi] ? -op_reg[gi] : op_reg[gi];
            assign op_sum[gi] = {1'b0, op_mag[gi][HALF-1:0]}
                              + {1'b0, op_mag[gi][WIDTH-1:HALF]};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Shared multiplier. The current state selects its operands. Half operands
    // are zero-extended to the HALF+1 width of the D/E sums.
    // -------------------------------------------------------------------------
    logic [MW-1:0] mul_x;
    logic [MW-1:0] mul_y;
    logic [PW-1:0] mul_p;

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_reg)
            MUL_A: begin
                mul_x = {1'b0, mag_reg[0][HALF-1:0]};
                mul_y = {1'b0, mag_reg[1][HALF-1:0]};
            end
            MUL_B: begin
                mul_x = {1'b0, mag_reg[0][WIDTH-1:HALF]};
                mul_y = {1'b0, mag_reg[1][WIDTH-1:HALF]};
            end
            MUL_DE: begin
                mul_x = sum_reg[0];
                mul_y = sum_reg[1];
            end
            default: ;
        endcase
    end

    assign mul_p = {{MW{1'b0}}, mul_x} * {{MW{1'b0}}, mul_y};

    // -------------------------------------------------------------------------
    // Recombination. The middle term DE - A - B equals wl*yh + wh*yl. It is
    // therefore non-negative and fits in WIDTH+1 bits. The full sum cannot
    // exceed (2^WIDTH - 1)^2, so it never overflows 2*WIDTH bits.
    // -------------------------------------------------------------------------
    logic [PW-1:0] mid;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] mid_ext;
    logic [RW-1:0] p_sum;

    assign mid     = de_reg - a_reg - b_reg;
    assign a_ext   = {{(RW-PW){1'b0}}, a_reg};
    assign b_ext   = {{(RW-PW){1'b0}}, b_reg} << WIDTH;
    assign mid_ext = {{(RW-PW){1'b0}}, mid} << HALF;
    assign p_sum   = b_ext + mid_ext + a_ext;

    // -------------------------------------------------------------------------
    // Controller: next state and next values of every register.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        mode_next   = mode_reg;
        mag_next    = mag_reg;
        sum_next    = sum_reg;
        neg_next    = neg_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        de_next     = de_reg;
        p_next      = p_reg;
        result_next = result_reg;
        pronto_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (S) begin
                    op_next    = {y, w};
                    mode_next  = SIGNED_MODE;
                    state_next = PREP;
                end
            end
            PREP: begin
                mag_next   = op_mag;
                sum_next   = op_sum;
                neg_next   = op_neg[0] ^ op_neg[1];
                state_next = MUL_A;
            end
            MUL_A: begin
                a_next     = mul_p;
                state_next = MUL_B;
            end
            MUL_B: begin
                b_next     = mul_p;
                state_next = MUL_DE;
            end
            MUL_DE: begin
                de_next    = mul_p;
                state_next = COMBINE;
            end
            COMBINE: begin
                p_next     = p_sum;
                state_next = FINISH;
            end
            FINISH: begin
                result_next = neg_reg ? -p_reg : p_reg;
                pronto_next = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            mode_reg   <= 1'b0;
            mag_reg    <= '0;
            sum_reg    <= '0;
            neg_reg    <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            de_reg     <= '0;
            p_reg      <= '0;
            result_reg <= '0;
            pronto_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            mode_reg   <= mode_next;
            mag_reg    <= mag_next;
            sum_reg    <= sum_next;
            neg_reg    <= neg_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            de_reg     <= de_next;
            p_reg      <= p_next;
            result_reg <= result_next;
            pronto_reg <= pronto_next;
        end
    end

    assign result = result_reg;
    assign PRONTO = pronto_reg;
    assign BUSY   = (state_reg != IDLE);

endmodule
